// File: rtl/instr_fetch_queue.sv
// Instruction-fetch unit: program-loaded instruction memory, PC sequencer and credit-throttled issue queue.
// Optional build macro IFQ_PC_TAG_EN adds issue_pc, the fetch address of the queue-head instruction.
module instr_fetch_queue #(
  parameter int INSTR_W = 16,
  parameter int ADDR_W  = 4,
  parameter int QDEPTH  = 4
) (
  input  logic               clk1,
  input  logic               rst_n,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic [ADDR_W:0]    prog_len,
  input  logic               redir_valid,
  input  logic [ADDR_W-1:0]  redir_pc,
  output logic               issue_valid,
  input  logic               issue_ready,
  output logic [INSTR_W-1:0] issue_instr,
`ifdef IFQ_PC_TAG_EN
  output logic [ADDR_W-1:0]  issue_pc,
`endif
  output logic               busy,
  output logic               done
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int PC_W  = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_n;
  logic [PC_W-1:0]    pc, pc_n;
  logic [CNT_W-1:0]   count, count_n;
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic               inflight;
  logic               fetch, push, pop;
  logic [INSTR_W-1:0] head_instr_n;

  logic [INSTR_W-1:0] mem     [2**ADDR_W];
  logic [INSTR_W-1:0] q_instr [QDEPTH];
  logic [INSTR_W-1:0] rdata;

`ifdef IFQ_PC_TAG_EN
  logic [ADDR_W-1:0]  q_pc [QDEPTH];
  logic [ADDR_W-1:0]  rd_pc;
  logic [ADDR_W-1:0]  head_pc_n;
`endif

  // NOTE: every signal assigned here gets a default first, so no path leaves a latch behind.
  always_comb begin
    pop          = issue_ready && (count != '0);
    push         = inflight && !redir_valid;
    fetch        = !redir_valid && (state == RUN) && (pc < prog_len) &&
                   ((count + CNT_W'(inflight)) < CNT_W'(QDEPTH));
    state_n      = state;
    pc_n         = pc;
    count_n      = count + CNT_W'(push) - CNT_W'(pop);
    head_instr_n = issue_instr;
`ifdef IFQ_PC_TAG_EN
    head_pc_n    = issue_pc;
`endif

    if (redir_valid) begin
      pc_n    = {1'b0, redir_pc};
      state_n = ({1'b0, redir_pc} >= prog_len) ? DONE : RUN;
      count_n = '0;
    end else if (state == RUN) begin
      if (fetch) pc_n = pc + PC_W'(1);
      if (pc_n >= prog_len) state_n = DONE;
    end

    // The head register tracks whichever entry sits at the front after this edge.
    if (!redir_valid) begin
      if ((count - CNT_W'(pop)) != '0) begin
        head_instr_n = q_instr[rd_ptr + PTR_W'(pop)];
`ifdef IFQ_PC_TAG_EN
        head_pc_n    = q_pc[rd_ptr + PTR_W'(pop)];
`endif
      end else if (push) begin
        head_instr_n = rdata;
`ifdef IFQ_PC_TAG_EN
        head_pc_n    = rd_pc;
`endif
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      inflight    <= 1'b0;
      issue_valid <= 1'b0;
      issue_instr <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef IFQ_PC_TAG_EN
      issue_pc    <= '0;
`endif
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      count       <= count_n;
      inflight    <= fetch;
      issue_valid <= (count_n != '0);
      issue_instr <= head_instr_n;
      busy        <= (state_n == RUN);
      done        <= (state_n == DONE) && (count_n == '0) && !fetch;
`ifdef IFQ_PC_TAG_EN
      issue_pc    <= head_pc_n;
`endif
      if (redir_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        rd_ptr <= rd_ptr + PTR_W'(pop);
        wr_ptr <= wr_ptr + PTR_W'(push);
      end
    end
  end

  // NOTE: storage arrays carry no reset; their contents are only observed once written.
  always_ff @(posedge clk1) begin
    if (prog_we) mem[prog_addr] <= prog_data;
    if (fetch)   rdata <= mem[pc[ADDR_W-1:0]];
    if (push)    q_instr[wr_ptr] <= rdata;
`ifdef IFQ_PC_TAG_EN
    if (fetch)   rd_pc <= pc[ADDR_W-1:0];
    if (push)    q_pc[wr_ptr] <= rd_pc;
`endif
  end

  // Credits guarantee a push never lands on a full queue.
  assert property (@(posedge clk1) disable iff (!rst_n)
    !(push && !pop && (count == CNT_W'(QDEPTH))));

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: fill/drain, backpressure, redirect, boundaries, async reset.
// Define IFQ_PC_TAG_EN for both bench and RTL to cover issue_pc.
module tb_instr_fetch_queue;

  logic        clk1 = 1'b0;
  logic        rst_n;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [15:0] prog_data;
  logic [4:0]  prog_len;
  logic        redir_valid;
  logic [3:0]  redir_pc;
  logic        issue_valid;
  logic        issue_ready;
  logic [15:0] issue_instr;
  logic        busy;
  logic        done;
`ifdef IFQ_PC_TAG_EN
  logic [3:0]  issue_pc;
`endif

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] prog6 [6] = '{16'h2123, 16'h0345, 16'h0267, 16'h089A, 16'h27AB, 16'h1535};

  always #5 clk1 = ~clk1;

  instr_fetch_queue #(.INSTR_W(16), .ADDR_W(4), .QDEPTH(4)) dut (
    .clk1        (clk1),
    .rst_n       (rst_n),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_len    (prog_len),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_instr (issue_instr),
`ifdef IFQ_PC_TAG_EN
    .issue_pc    (issue_pc),
`endif
    .busy        (busy),
    .done        (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic prog_write(input logic [3:0] a, input logic [15:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    step();
    prog_we   = 1'b0;
  endtask

  task automatic redirect(input logic [3:0] p);
    redir_valid = 1'b1;
    redir_pc    = p;
    step();
    redir_valid = 1'b0;
  endtask

  // Pops with ready held high; which=0 expects prog6, which=1 expects 16'hA000+i.
  task automatic collect(input string tag, input int n, input int which);
    int got_n = 0;
    logic [15:0] exp;
    issue_ready = 1'b1;
    for (int c = 0; c < 80 && got_n < n; c++) begin
      if (issue_valid) begin
        exp = (which == 0) ? prog6[got_n] : 16'hA000 + 16'(got_n);
        check(tag, issue_instr, exp);
        got_n++;
      end
      step();
    end
    check({tag, "_count"}, got_n, n);
  endtask

  initial begin
    rst_n       = 1'b0;
    prog_we     = 1'b0;
    prog_addr   = '0;
    prog_data   = '0;
    prog_len    = 5'd0;
    redir_valid = 1'b0;
    redir_pc    = '0;
    issue_ready = 1'b0;
    #7;
    check("rst_valid", issue_valid, 0);
    check("rst_instr", issue_instr, 0);
    check("rst_busy",  busy, 0);
    check("rst_done",  done, 0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 6; i++) prog_write(4'(i), prog6[i]);
    prog_len = 5'd6;

    // Fill and drain with ready held high: two-cycle latency, then one word per cycle.
    issue_ready = 1'b1;
    redirect(4'd0);
    check("fill_busy",    busy, 1);
    check("fill_valid_0", issue_valid, 0);
    step();
    check("fill_valid_1", issue_valid, 0);
    step();
    for (int i = 0; i < 6; i++) begin
      check("fill_valid", issue_valid, 1);
      check("fill_word",  issue_instr, prog6[i]);
      step();
    end
    check("fill_end_valid", issue_valid, 0);
    check("fill_done",      done, 1);
    check("fill_busy_end",  busy, 0);

    // Backpressure: the queue saturates, nothing is overwritten while stalled.
    issue_ready = 1'b0;
    redirect(4'd0);
    for (int i = 0; i < 10; i++) step();
    check("bp_valid", issue_valid, 1);
    check("bp_head",  issue_instr, 16'h2123);
    check("bp_busy",  busy, 1);
    check("bp_done",  done, 0);
    collect("bp_word", 6, 0);
    check("bp_end_valid", issue_valid, 0);
    check("bp_done_end",  done, 1);

    // Redirect mid-stream after two pops; the second pop coincides with the redirect.
    issue_ready = 1'b1;
    redirect(4'd0);
    step();
    step();
    check("rd_w0", issue_instr, 16'h2123);
    step();
    check("rd_w1", issue_instr, 16'h0345);
    redirect(4'd4);
    check("rd_flush_valid", issue_valid, 0);
    check("rd_flush_busy",  busy, 1);
    step();
    check("rd_gap_valid", issue_valid, 0);
    step();
    check("rd_valid_a", issue_valid, 1);
    check("rd_word_a",  issue_instr, 16'h27AB);
`ifdef IFQ_PC_TAG_EN
    check("rd_pc_a", issue_pc, 4);
`endif
    step();
    check("rd_valid_b", issue_valid, 1);
    check("rd_word_b",  issue_instr, 16'h1535);
`ifdef IFQ_PC_TAG_EN
    check("rd_pc_b", issue_pc, 5);
`endif
    step();
    check("rd_end_valid", issue_valid, 0);
    check("rd_done",      done, 1);

    // Empty program: redirect lands straight in DONE.
    prog_len = 5'd0;
    redirect(4'd0);
    check("len0_done", done, 1);
    check("len0_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      check("len0_valid", issue_valid, 0);
      step();
    end

    // Full-depth program: 16 words, no PC wrap afterwards.
    for (int i = 0; i < 16; i++) prog_write(4'(i), 16'hA000 + 16'(i));
    prog_len = 5'd16;
    redirect(4'd0);
    collect("len16_word", 16, 1);
    check("len16_done", done, 1);
    for (int i = 0; i < 3; i++) begin
      check("len16_nowrap", issue_valid, 0);
      step();
    end

    // Asynchronous reset between edges, then memory contents survive.
    issue_ready = 1'b0;
    redirect(4'd0);
    step();
    step();
    step();
    check("ar_pre_valid", issue_valid, 1);
    check("ar_pre_busy",  busy, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_valid", issue_valid, 0);
    check("ar_busy",  busy, 0);
    check("ar_done",  done, 0);
    #2;
    rst_n = 1'b1;
    issue_ready = 1'b1;
    redirect(4'd0);
    step();
    step();
    check("ar_mem0", issue_instr, 16'hA000);
    step();
    check("ar_mem1", issue_instr, 16'hA001);
    step();
    check("ar_mem2", issue_instr, 16'hA002);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Parametrised instruction-fetch unit: on-chip instruction memory plus a PC sequencer and a small instruction queue feeding the issue/dispatch stage of the Tomasulo core.
- Memory is loaded through an explicit write port, not by hierarchical initialisation.
- Fetch is self-paced, throttled by queue credits, and restartable at any PC via a redirect.
- The issue side consumes instructions with a valid/ready handshake.

Parameters:
- INSTR_W, 16: instruction width in bits.
- ADDR_W, 4: PC/memory address width; memory depth = 2**ADDR_W words.
- QDEPTH, 4: instruction-queue entries; a power of 2, at least 2.

Ports:
- clk1  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- prog_we  in  1  memory write enable.
- prog_addr  in  ADDR_W  memory write address.
- prog_data  in  INSTR_W  memory write data.
- prog_len  in  ADDR_W+1  number of valid instructions, range 0..2**ADDR_W.
- redir_valid  in  1  start/restart fetch at redir_pc.
- redir_pc  in  ADDR_W  new fetch PC.
- issue_valid  out  1  queue head holds a valid instruction.
- issue_ready  in  1  consumer accepts the head.
- issue_instr  out  INSTR_W  queue head instruction.
- busy  out  1  state is RUN.
- done  out  1  state is DONE and the queue is empty.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc=0, queue empty, inflight=0.
  - issue_valid=0, issue_instr=0, busy=0, done=0.
  - Memory contents are not reset.
- Memory write:
  - prog_we=1 writes prog_data to mem[prog_addr] at the clock edge.
  - Writes are legal in any state.
  - A read of the same address in the same cycle returns the old data (read-before-write).
- Memory read:
  - Synchronous, 1-cycle latency.
  - A fetch issued in cycle N pushes mem[pc] into the queue at the end of cycle N+1. The inflight flag marks that read.
- States:
  - IDLE: no fetch. redir_valid moves to RUN with pc=redir_pc.
  - RUN: fetch when pc < prog_len and count + inflight < QDEPTH. Each fetch sets pc=pc+1, computed in ADDR_W+1 bits so there is no wrap. When pc reaches prog_len, move to DONE; the outstanding inflight read still completes.
  - DONE: no fetch. redir_valid moves to RUN.
  - redir_valid in RUN with redir_pc >= prog_len moves directly to DONE.
- Redirect (any non-IDLE state, or from IDLE):
  - Queue cleared and inflight read discarded in the same cycle.
  - pc=redir_pc.
  - First fetch at redir_pc occurs in the following cycle.
  - Redirect takes priority over a simultaneous pop; the popped instruction is still considered consumed.
- Queue:
  - Circular buffer; pointers are log2(QDEPTH) bits and wrap naturally.
  - count is log2(QDEPTH)+1 bits.
  - Push and pop in the same cycle leave count unchanged.
  - A pop when empty is ignored.
  - Push when full cannot occur because of the credit rule; an assertion checks this in simulation.
- Outputs:
  - issue_valid = (count != 0).
  - issue_instr shows the head entry, registered; it holds its value while issue_valid=0.
  - busy = (state == RUN).
  - done = (state == DONE) and count == 0 and inflight == 0.
- Boundary cases:
  - prog_len=0: a redirect goes straight to DONE.
  - prog_len=2**ADDR_W: the last fetch is at pc=2**ADDR_W-1, then DONE.
  - Asserting rst_n low mid-run aborts immediately, including inflight reads.

Optional Feature:
- Macro IFQ_PC_TAG_EN.
- When defined:
  - Extra output port issue_pc [ADDR_W-1:0] carries the PC of the queue-head instruction.
  - Each queue entry stores its PC alongside the instruction.
  - issue_pc resets to 0.
  - This lets reservation stations and the ROB record the instruction address.
- When undefined: the port and PC storage are absent, and the rest of the behaviour is identical.

Test Plan:
- Program fill and drain:
  - Stimulus: write mem[0..5] = 16'h2123, 16'h0345, 16'h0267, 16'h089A, 16'h27AB, 16'h1535; prog_len=6; redir_pc=0; issue_ready held 1.
  - Response: issue_valid first rises 2 cycles after redirect; the six words emerge in order on consecutive cycles; done=1 after the last pop.
- Backpressure:
  - Stimulus: same program, issue_ready=0.
  - Response: count saturates at QDEPTH=4; no fetch while full; releasing ready yields 16'h2123..16'h1535 with none lost or duplicated.
- Redirect mid-stream:
  - Stimulus: after two pops, redir_pc=4.
  - Response: queue is flushed; the next issued words are 16'h27AB, then 16'h1535, then done=1.
- Boundary:
  - Stimulus: prog_len=0 with a redirect → response: done=1 next cycle, issue_valid never 1.
  - Stimulus: prog_len=16 → response: 16 words issued, pc does not wrap.
- Async reset:
  - Stimulus: assert rst_n=0 mid-run, between clock edges.
  - Response: issue_valid/busy/done go to 0 immediately; memory contents are retained after release.
- IFQ_PC_TAG_EN:
  - Stimulus: rerun the redirect case with the macro defined.
  - Response: issue_pc = 4 with 16'h27AB and 5 with 16'h1535.
